// File: rtl/wb_mem_unit.sv
// Wishbone classic load/store unit: one request at a time, byte-lane select, aligned/extended load data.
// Optional bus timeout (error code 3) is built when WB_MEM_TIMEOUT_EN is defined.
module wb_mem_unit #(
   parameter int DAT_WIDTH = 64,
   parameter int ADR_WIDTH = 64,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [1:0]             req_size_i,
   input  logic                   req_signed_i,
   input  logic [ADR_WIDTH-1:0]   req_adr_i,
   input  logic [DAT_WIDTH-1:0]   req_dat_i,
   output logic                   rsp_valid_o,
   output logic [DAT_WIDTH-1:0]   rsp_dat_o,
   output logic [1:0]             rsp_err_o,
   output logic [ADR_WIDTH-1:0]   wb_adr_o,
   output logic [DAT_WIDTH-1:0]   wb_dat_o,
   input  logic [DAT_WIDTH-1:0]   wb_dat_i,
   output logic                   wb_we_o,
   output logic [DAT_WIDTH/8-1:0] wb_sel_o,
   output logic                   wb_stb_o,
   output logic                   wb_cyc_o,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i
);

   // state | meaning
   // IDLE  | ready for a request
   // BUS   | Wishbone cycle in flight
   // RESP  | publish result: first cycle raises rsp_valid_o, second returns to IDLE
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int NB   = DAT_WIDTH / 8;
   localparam int OFFW = $clog2(NB);

   logic [1:0]           state;
   logic [1:0]           size_q;
   logic                 signed_q;
   logic [OFFW-1:0]      off_q;

   logic [OFFW-1:0]      req_off;
   logic [3:0]           req_nb;
   logic                 req_illegal;
   logic [7:0]           sel_base;
   logic [NB-1:0]        req_sel;
   logic [DAT_WIDTH-1:0] req_wdat;
   logic [DAT_WIDTH-1:0] rd_shift;
   logic [DAT_WIDTH-1:0] rd_ext;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt;
`endif

   always_comb begin
      req_off     = req_adr_i[OFFW-1:0];
      req_nb      = 4'd1 << req_size_i;
      req_illegal = ((4'(req_off) & (req_nb - 4'd1)) != 4'd0) || (req_nb > 4'(NB));
      case (req_size_i)
         2'd0:    sel_base = 8'h01;
         2'd1:    sel_base = 8'h03;
         2'd2:    sel_base = 8'h0F;
         default: sel_base = 8'hFF;
      endcase
      req_sel = NB'(sel_base) << req_off;
      // an 8-byte store only reaches here legally on a 64-bit bus, where it fills the bus as-is
      case (req_size_i)
         2'd0:    req_wdat = {NB{req_dat_i[7:0]}};
         2'd1:    req_wdat = {(NB/2){req_dat_i[15:0]}};
         2'd2:    req_wdat = {(NB/4){req_dat_i[31:0]}};
         default: req_wdat = req_dat_i;
      endcase
   end

   always_comb begin
      rd_shift = wb_dat_i >> {off_q, 3'b000};
      case (size_q)
         2'd0:    rd_ext = signed_q ? DAT_WIDTH'($signed(rd_shift[7:0]))  : DAT_WIDTH'(rd_shift[7:0]);
         2'd1:    rd_ext = signed_q ? DAT_WIDTH'($signed(rd_shift[15:0])) : DAT_WIDTH'(rd_shift[15:0]);
         2'd2:    rd_ext = signed_q ? DAT_WIDTH'($signed(rd_shift[31:0])) : DAT_WIDTH'(rd_shift[31:0]);
         default: rd_ext = rd_shift;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 2'd0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_sel_o    <= '0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         size_q      <= 2'd0;
         signed_q    <= 1'b0;
         off_q       <= '0;
`ifdef WB_MEM_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  size_q      <= req_size_i;
                  signed_q    <= req_signed_i;
                  off_q       <= req_off;
                  if (req_illegal) begin
                     state     <= S_RESP;
                     rsp_err_o <= 2'd1;
                     rsp_dat_o <= '0;
                  end else begin
                     state    <= S_BUS;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_we_o  <= req_we_i;
                     wb_adr_o <= req_adr_i;
                     wb_sel_o <= req_sel;
                     wb_dat_o <= req_wdat;
`ifdef WB_MEM_TIMEOUT_EN
                     tmo_cnt  <= '0;
`endif
                  end
               end
            end
            S_BUS: begin
               if (wb_err_i) begin
                  rsp_err_o <= 2'd2;
                  rsp_dat_o <= '0;
                  state     <= S_RESP;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
               end else if (wb_ack_i) begin
                  rsp_err_o <= 2'd0;
                  rsp_dat_o <= wb_we_o ? '0 : rd_ext;
                  state     <= S_RESP;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
               end
`ifdef WB_MEM_TIMEOUT_EN
               else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                  rsp_err_o <= 2'd3;
                  rsp_dat_o <= '0;
                  state     <= S_RESP;
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (!rsp_valid_o) begin
                  rsp_valid_o <= 1'b1;
               end else begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state       <= S_IDLE;
               req_ready_o <= 1'b1;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_mem_unit.sv
// Directed bench for wb_mem_unit (64-bit data, 64-bit address): vector table plus hand-written
// sequences for bus error, wait states and reset during a bus cycle.
module tb_wb_mem_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_signed_i;
   logic [63:0] req_adr_i;
   logic [63:0] req_dat_i;
   logic        rsp_valid_o;
   logic [63:0] rsp_dat_o;
   logic [1:0]  rsp_err_o;
   logic [63:0] wb_adr_o;
   logic [63:0] wb_dat_o;
   logic [63:0] wb_dat_i;
   logic        wb_we_o;
   logic [7:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk_i = ~clk_i;

   wb_mem_unit #(.DAT_WIDTH(64), .ADR_WIDTH(64), .TIMEOUT(255)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_adr_i(req_adr_i),
      .req_dat_i(req_dat_i), .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
      .rsp_err_o(rsp_err_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [63:0] adr;
      logic [63:0] din;
      logic [63:0] rdat;
      int          waits;
      logic [7:0]  sel;
      logic [63:0] wdat;
      logic [63:0] rsp;
      logic [1:0]  err;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic drive_req(input vec_t v);
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_we_i     = v.we;
      req_size_i   = v.size;
      req_signed_i = v.sgn;
      req_adr_i    = v.adr;
      req_dat_i    = v.din;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("v%0d", idx);
      drive_req(v);
      chk({nm, "_ready_busy"}, 64'(req_ready_o), 64'd0);
      if (v.err == 2'd1) begin
         chk({nm, "_no_cyc"}, 64'(wb_cyc_o), 64'd0);
         @(posedge clk_i); #1;
         chk({nm, "_valid"}, 64'(rsp_valid_o), 64'd1);
         chk({nm, "_err"}, 64'(rsp_err_o), 64'd1);
         chk({nm, "_cyc_still_low"}, 64'(wb_cyc_o), 64'd0);
      end else begin
         chk({nm, "_cyc"}, 64'(wb_cyc_o), 64'd1);
         chk({nm, "_stb"}, 64'(wb_stb_o), 64'd1);
         chk({nm, "_we"}, 64'(wb_we_o), 64'(v.we));
         chk({nm, "_sel"}, 64'(wb_sel_o), 64'(v.sel));
         chk({nm, "_adr"}, wb_adr_o, v.adr);
         if (v.we) chk({nm, "_wdat"}, wb_dat_o, v.wdat);
         for (int w = 0; w < v.waits; w++) begin
            @(posedge clk_i); #1;
            chk({nm, "_cyc_hold"}, 64'(wb_cyc_o), 64'd1);
            chk({nm, "_we_hold"}, 64'(wb_we_o), 64'(v.we));
            chk({nm, "_sel_hold"}, 64'(wb_sel_o), 64'(v.sel));
         end
         wb_ack_i = 1'b1;
         wb_dat_i = v.rdat;
         @(posedge clk_i); #1;
         wb_ack_i = 1'b0;
         wb_dat_i = 64'hDEAD_DEAD_DEAD_DEAD;
         chk({nm, "_cyc_drop"}, 64'(wb_cyc_o), 64'd0);
         chk({nm, "_we_drop"}, 64'(wb_we_o), 64'd0);
         chk({nm, "_valid_early"}, 64'(rsp_valid_o), 64'd0);
         @(posedge clk_i); #1;
         chk({nm, "_valid"}, 64'(rsp_valid_o), 64'd1);
         chk({nm, "_err"}, 64'(rsp_err_o), 64'(v.err));
         chk({nm, "_rdat"}, rsp_dat_o, v.rsp);
      end
      @(posedge clk_i); #1;
      chk({nm, "_valid_pulse"}, 64'(rsp_valid_o), 64'd0);
      chk({nm, "_ready_back"}, 64'(req_ready_o), 64'd1);
      chk({nm, "_err_hold"}, 64'(rsp_err_o), 64'(v.err));
   endtask

   initial begin
      vec_t v;
      //            we    size  sgn   adr                     din                     rdat                    w  sel    wdat                    rsp                     err
      vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'h0000_8000_0000_0000, 64'h0,                  64'h1122_3344_5566_7788, 0, 8'hFF, 64'h0,                  64'h1122_3344_5566_7788, 2'd0};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 64'h5,                   64'h0,                  64'h0000_8000_0000_0000, 0, 8'h20, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 2'd0};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 64'h5,                   64'h0,                  64'h0000_8000_0000_0000, 0, 8'h20, 64'h0,                  64'h80,                  2'd0};
      vecs[3]  = '{1'b1, 2'd1, 1'b0, 64'h6,                   64'h1234_5678_9ABC_BEEF, 64'h0,                  3, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0,                  2'd0};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 64'h2,                   64'h0,                  64'h0,                  0, 8'h00, 64'h0,                  64'h0,                  2'd1};
      vecs[5]  = '{1'b0, 2'd1, 1'b1, 64'h4,                   64'h0,                  64'h0000_ABCD_0000_0000, 1, 8'h30, 64'h0,                  64'hFFFF_FFFF_FFFF_ABCD, 2'd0};
      vecs[6]  = '{1'b0, 2'd2, 1'b1, 64'h0,                   64'h0,                  64'hFFFF_FFFF_7FFF_FFFF, 0, 8'h0F, 64'h0,                  64'h7FFF_FFFF,           2'd0};
      vecs[7]  = '{1'b0, 2'd2, 1'b1, 64'h1004,                64'h0,                  64'h8765_4321_0000_0000, 2, 8'hF0, 64'h0,                  64'hFFFF_FFFF_8765_4321, 2'd0};
      vecs[8]  = '{1'b1, 2'd0, 1'b0, 64'h3,                   64'hFFFF_FFFF_FFFF_FFA5, 64'h0,                  1, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0,                  2'd0};
      vecs[9]  = '{1'b1, 2'd2, 1'b0, 64'hC,                   64'h0000_0000_DEAD_BEEF, 64'h0,                  0, 8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                  2'd0};
      vecs[10] = '{1'b0, 2'd3, 1'b0, 64'h4,                   64'h0,                  64'h0,                  0, 8'h00, 64'h0,                  64'h0,                  2'd1};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 64'h7,                   64'hFFFF,               64'h0,                  0, 8'h00, 64'h0,                  64'h0,                  2'd1};
      vecs[12] = '{1'b0, 2'd0, 1'b0, 64'h7,                   64'h0,                  64'hFE00_0000_0000_0000, 0, 8'h80, 64'h0,                  64'hFE,                  2'd0};
      vecs[13] = '{1'b0, 2'd1, 1'b0, 64'hA,                   64'h0,                  64'h0000_0000_F00D_0000, 0, 8'h0C, 64'h0,                  64'hF00D,                2'd0};

      rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
      req_signed_i = 1'b0; req_adr_i = '0; req_dat_i = '0;
      wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ready", 64'(req_ready_o), 64'd1);
      chk("rst_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_rdat", rsp_dat_o, 64'd0);
      chk("rst_err", 64'(rsp_err_o), 64'd0);
      chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
      chk("rst_stb", 64'(wb_stb_o), 64'd0);
      chk("rst_we", 64'(wb_we_o), 64'd0);
      chk("rst_sel", 64'(wb_sel_o), 64'd0);
      chk("rst_adr", wb_adr_o, 64'd0);
      chk("rst_wdat", wb_dat_o, 64'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // err and ack together: bus error wins, data forced to zero
      v = vecs[0];
      drive_req(v);
      wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge clk_i); #1;
      wb_err_i = 1'b0; wb_ack_i = 1'b0;
      chk("buserr_cyc_drop", 64'(wb_cyc_o), 64'd0);
      @(posedge clk_i); #1;
      chk("buserr_valid", 64'(rsp_valid_o), 64'd1);
      chk("buserr_err", 64'(rsp_err_o), 64'd2);
      chk("buserr_rdat", rsp_dat_o, 64'd0);
      @(posedge clk_i); #1;
      chk("buserr_ready", 64'(req_ready_o), 64'd1);

      // request held high while busy is taken only once per IDLE visit
      v = vecs[6];
      drive_req(v);
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      chk("busy_cyc_hold", 64'(wb_cyc_o), 64'd1);
      chk("busy_ready", 64'(req_ready_o), 64'd0);
      wb_ack_i = 1'b1; wb_dat_i = v.rdat;
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0;
      req_valid_i = 1'b0;
      @(posedge clk_i); #1;
      chk("busy_rdat", rsp_dat_o, 64'h7FFF_FFFF);
      @(posedge clk_i); #1;
      chk("busy_idle_ready", 64'(req_ready_o), 64'd1);
      chk("busy_no_cyc", 64'(wb_cyc_o), 64'd0);

      // reset during a bus cycle aborts silently
      v = vecs[0];
      drive_req(v);
      @(posedge clk_i); #1;
      chk("rstbus_cyc_before", 64'(wb_cyc_o), 64'd1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("rstbus_cyc", 64'(wb_cyc_o), 64'd0);
      chk("rstbus_stb", 64'(wb_stb_o), 64'd0);
      chk("rstbus_ready", 64'(req_ready_o), 64'd1);
      for (int k = 0; k < 4; k++) begin
         chk("rstbus_no_valid", 64'(rsp_valid_o), 64'd0);
         @(posedge clk_i); #1;
      end
      run_vec(vecs[1], 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
